serial_subtractor: RTL



---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/full_subtractor.sv | 13 +
 rtl/serial_subtractor.sv | 130 +++++++++++++
 3 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types and defaults for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } sub_state_t;

    localparam int SERIAL_WIDTH_DEF = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock through a single
// full-subtractor cell. Operands in and result out via valid/ready.
//
// state  | meaning
// S_IDLE | waiting for operands, in_ready high
// S_BUSY | shifting one bit per clock through the cell
// S_DONE | result held, out_valid high until out_ready
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = SERIAL_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    sub_state_t       state;
    sub_state_t       state_nxt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    // Holds the WIDTH-1 bits produced so far; the final bit is joined on the last edge.
    logic [WIDTH-2:0] diff_sh;
    logic [WIDTH-1:0] diff_nxt;
    logic [CW-1:0]    cnt;
    logic             br;
    logic             a_msb;
    logic             b_msb;
    logic             cell_d;
    logic             cell_bo;
    logic             accept;
    logic             last_bit;

    full_subtractor u_cell (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .bin  (br),
        .d    (cell_d),
        .bout (cell_bo)
    );

    assign diff_nxt = {cell_d, diff_sh};
    assign accept   = in_valid && in_ready;
    assign last_bit = (state == S_BUSY) && (cnt == LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt == LAST) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, bit-serial shifting and result registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            diff    <= '0;
            bout    <= 1'b0;
            ovf     <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            br    <= bin;
            cnt   <= '0;
            a_msb <= a[WIDTH-1];
            b_msb <= b[WIDTH-1];
        end else if (state == S_BUSY) begin
            a_sh    <= a_sh >> 1;
            b_sh    <= b_sh >> 1;
            diff_sh <= diff_nxt[WIDTH-1:1];
            br      <= cell_bo;
            cnt     <= cnt + CW'(1);
            if (last_bit) begin
                diff <= diff_nxt;
                bout <= cell_bo;
                ovf  <= (a_msb != b_msb) && (cell_d != a_msb);
            end
        end
    end

endmodule
